// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter/sequencer for the shared ALU (ALU_ARB_FIXED_PRIO_EN selects fixed priority to requester 0)
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [5:0]       req0_signal,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req1_signal,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_dataA,
  output logic [WIDTH-1:0] alu_dataB,
  output logic [5:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_dataOut
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic owner, err, g0, g1, idle;
  logic [WIDTH-1:0] result;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif
  function automatic logic legal(input logic [5:0] s);
    return s inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_signal <= 6'b000000;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      if (g0 | g1) begin
        alu_dataA  <= g1 ? req1_a : req0_a;
        alu_dataB  <= g1 ? req1_b : req0_b;
        alu_signal <= g1 ? req1_signal : req0_signal;
        owner      <= g1;
        err        <= !legal(g1 ? req1_signal : req0_signal);
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= g1;
`endif
      end
      if (state == EXEC) result <= err ? '0 : alu_dataOut;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? ((g0 | g1) ? EXEC : IDLE) :
               state == EXEC ? RESP :
               ((owner ? rsp1_ready : rsp0_ready) ? IDLE : RESP);
  end
  always_comb begin
    idle = state == IDLE;
`ifdef ALU_ARB_FIXED_PRIO_EN
    g0 = idle & req0_valid;
    g1 = idle & req1_valid & !req0_valid;
`else
    // on a tie the requester that did not win last time is granted
    g0 = idle & req0_valid & (!req1_valid | last_grant);
    g1 = idle & req1_valid & (!req0_valid | !last_grant);
`endif
    req0_ready = g0;
    req1_ready = g1;
    rsp0_valid = state == RESP && !owner;
    rsp1_valid = state == RESP && owner;
    rsp0_data  = result;
    rsp1_data  = result;
    rsp0_err   = err;
    rsp1_err   = err;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized + directed check of alu_arbiter against a transaction-level reference model
module tb_alu_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [5:0] req0_signal = 0, req1_signal = 0;
  logic rsp0_valid, rsp1_valid, rsp0_ready = 1, rsp1_ready = 1, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, alu_dataA, alu_dataB, alu_dataOut;
  logic [5:0] alu_signal;
  int checks = 0, failures = 0;
  int ph = 0;
  bit own = 0, lg = 1, ee = 0, just_reset = 1, last_err = 0;
  logic [31:0] ed = 0, ea = 0, eb = 0, last_data = 0;
  logic [5:0] es = 0;
  int grant_log[$];
  logic [5:0] codes [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_signal(req0_signal),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_signal(req1_signal),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal), .alu_dataOut(alu_dataOut)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] s);
    return s inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction
  function automatic logic [31:0] ref_alu(input logic [31:0] a, b, input logic [5:0] s);
    case (s)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction
  // the ALU seen by the DUT returns garbage for illegal codes so masking is exercised
  always_comb alu_dataOut = is_legal(alu_signal) ? ref_alu(alu_dataA, alu_dataB, alu_signal) : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int win;
    #1;
    win = -1;
    if (ph == 0) begin
      if (req0_valid && req1_valid) win = FIXED ? 0 : (lg ? 0 : 1);
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(win == 0));
    chk("req1_ready", 32'(req1_ready), 32'(win == 1));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ph == 2 && !own));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ph == 2 && own));
    if (just_reset) begin
      chk("rst_rsp0_data", rsp0_data, 0);
      chk("rst_rsp1_data", rsp1_data, 0);
      chk("rst_rsp0_err", 32'(rsp0_err), 0);
      chk("rst_rsp1_err", 32'(rsp1_err), 0);
      just_reset = 0;
    end
    if (ph == 2) begin
      chk("rsp_data", own ? rsp1_data : rsp0_data, ed);
      chk("rsp_err", 32'(own ? rsp1_err : rsp0_err), 32'(ee));
    end
    chk("alu_dataA", alu_dataA, ea);
    chk("alu_dataB", alu_dataB, eb);
    chk("alu_signal", 32'(alu_signal), 32'(es));
    if (reset) begin
      ph = 0; lg = 1; ea = 0; eb = 0; es = 0; just_reset = 1;
    end else if (ph == 0) begin
      if (win >= 0) begin
        own = win[0];
        lg = win[0];
        ea = own ? req1_a : req0_a;
        eb = own ? req1_b : req0_b;
        es = own ? req1_signal : req0_signal;
        ee = !is_legal(es);
        ed = ref_alu(ea, eb, es);
        grant_log.push_back(win);
        ph = 1;
      end
    end else if (ph == 1) ph = 2;
    else if (own ? rsp1_ready : rsp0_ready) begin
      last_data = own ? rsp1_data : rsp0_data;
      last_err = own ? rsp1_err : rsp0_err;
      ph = 0;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input bit who, input logic [31:0] a, b, input logic [5:0] s);
    if (who) begin req1_valid = 1; req1_a = a; req1_b = b; req1_signal = s; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_signal = s; end
    rsp0_ready = 1; rsp1_ready = 1;
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();
  endtask

  task automatic pulse_reset();
    reset = 1; step(); reset = 0;
  endtask

  function automatic logic [5:0] rand_code();
    return ($urandom_range(9) == 0) ? 6'($urandom) : codes[$urandom_range(4)];
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    run_op(0, 5, 7, 6'b100000);
    chk("add_data", last_data, 12);
    chk("add_err", 32'(last_err), 0);
    run_op(1, 3, 5, 6'b100010);
    chk("sub_data", last_data, 32'hFFFFFFFE);
    run_op(1, 3, 5, 6'b101010);
    chk("slt_lt", last_data, 1);
    run_op(1, 5, 3, 6'b101010);
    chk("slt_ge", last_data, 0);
    run_op(0, 9, 4, 6'b000011);
    chk("illegal_data", last_data, 0);
    chk("illegal_err", 32'(last_err), 1);
    // backpressure: response held four cycles while both requesters wait
    req0_valid = 1; req0_a = 32'h1234; req0_b = 32'h1111; req0_signal = 6'b100101; rsp0_ready = 0;
    step();
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_signal = 6'b100000;
    repeat (5) step();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
    step();
    chk("bp_data", last_data, 32'h1335);
    step();
    // reset while in EXEC discards the op
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_signal = 6'b100000;
    step();
    req0_valid = 0; reset = 1;
    step();
    reset = 0;
    repeat (4) step();
    run_op(0, 32'hF0F0, 32'hFF00, 6'b100100);
    chk("and_data", last_data, 32'hF000);
    pulse_reset();
    grant_log.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 12; i++) begin
      req0_a = $urandom; req0_b = $urandom; req0_signal = codes[$urandom_range(4)];
      req1_a = $urandom; req1_b = $urandom; req1_signal = codes[$urandom_range(4)];
      step();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();
    chk("rr_grants", 32'(grant_log.size()), 4);
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(grant_log[i]), FIXED ? 0 : 32'(i % 2));
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(99) == 0);
      req0_valid = $urandom_range(1); req1_valid = $urandom_range(1);
      req0_a = $urandom; req0_b = ($urandom_range(3) == 0) ? req0_a : $urandom; req0_signal = rand_code();
      req1_a = $urandom; req1_b = $urandom; req1_signal = rand_code();
      rsp0_ready = ($urandom_range(9) < 7); rsp1_ready = ($urandom_range(9) < 7);
      step();
    end
    reset = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
